// File: rtl/population_uart_tx.sv
// population_uart_tx: snapshots the population bus and streams it LSB-first as 8N1 bytes; define POP_TX_CHECKSUM_EN to append an XOR checksum frame
module population_uart_tx #(
  parameter int POP_BITS     = 7500,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [POP_BITS-1:0] population,
  output logic                tx,
  output logic                busy,
  output logic                done
);
  localparam int NUM_BYTES = (POP_BITS + 7) / 8;
  localparam int SW = 8 * NUM_BYTES;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(NUM_BYTES + 1);
`ifdef POP_TX_CHECKSUM_EN
  localparam int LAST = NUM_BYTES;
`else
  localparam int LAST = NUM_BYTES - 1;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [IW-1:0] byte_idx;
  logic [SW-1:0] shadow;
  logic [7:0] cur;
  logic start_q, accept, wrap, last, adv, tx_n;
  assign accept = start & ~start_q & (state == IDLE);
  assign wrap = baud == BW'(CLKS_PER_BIT - 1);
  assign last = byte_idx == IW'(LAST);
  assign adv = (state == STOP) & wrap & ~last;
`ifdef POP_TX_CHECKSUM_EN
  logic [7:0] acc;
  assign cur = last ? acc : shadow[7:0];
  // running XOR of payload bytes, folded in as each byte's stop bit ends
  always_ff @(posedge clk)
    if (rst || accept) acc <= '0;
    else if (adv) acc <= acc ^ shadow[7:0];
`else
  assign cur = shadow[7:0];
`endif
  // next state, baud/bit counters and the next tx level
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? START : IDLE;
      START:   state_n = wrap ? DATA : START;
      DATA:    state_n = (wrap && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    state_n = wrap ? (last ? DONE : START) : STOP;
      default: state_n = IDLE;
    endcase
    baud_n = (state == IDLE || state == DONE || wrap) ? '0 : baud + 1'b1;
    bit_n = (state != DATA) ? '0 : bit_idx + 3'(wrap);
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? cur[bit_n] : 1'b1;
  end
  // state, counters, snapshot shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      shadow <= '0;
      start_q <= 1'b0;
      tx <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_n;
      start_q <= start;
      tx <= tx_n;
      busy <= state_n inside {START, DATA, STOP};
      done <= state_n == DONE;
      if (accept) begin
        shadow <= SW'(population);
        byte_idx <= '0;
      end else if (adv) begin
        shadow <= shadow >> 8;
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end
endmodule
